// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - framed byte-stream loader for the 18-bit instruction memory
module instr_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [17:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [8:0]        word_cnt;
    logic [7:0]        sum;
    logic [1:0]        sm;
    logic [7:0]        d1;
    logic              accept;
    logic              csum_ok;
    logic              session_start;

    // in_ready is registered, so acceptance never depends combinationally on in_valid
    assign accept        = in_valid && in_ready;
    assign csum_ok       = (sum + in_data) == 8'd0;
    assign session_start = start && (state == S_IDLE || state == S_ERR);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start) nxt = S_COUNT;
            S_COUNT: if (accept) begin
                if (int'(in_data) > DEPTH) nxt = S_ERR;
                else if (in_data == 8'd0)  nxt = S_CSUM;
                else                       nxt = S_B0;
            end
            S_B0:    if (accept) nxt = (in_data[7:2] != 6'd0) ? S_ERR : S_B1;
            S_B1:    if (accept) nxt = S_B2;
            S_B2:    if (accept) nxt = S_WRITE;
            S_WRITE: nxt = (word_cnt > 9'd1) ? S_B0 : S_CSUM;
            S_CSUM:  if (accept) nxt = csum_ok ? S_DONE : S_ERR;
            S_DONE:  nxt = S_IDLE;
            S_ERR:   if (start) nxt = S_COUNT;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            addr_cnt <= '0;
            word_cnt <= '0;
            sum      <= '0;
            sm       <= '0;
            d1       <= '0;
        end else begin
            state    <= nxt;
            in_ready <= (nxt == S_COUNT) || (nxt == S_B0) || (nxt == S_B1) ||
                        (nxt == S_B2) || (nxt == S_CSUM);
            im_we    <= (nxt == S_WRITE);
            cpu_hold <= (nxt != S_IDLE) && (nxt != S_DONE);
            busy     <= (nxt != S_IDLE) && (nxt != S_ERR);
            done     <= (nxt == S_DONE);
            err      <= (nxt == S_ERR);

            if (session_start) begin
                addr_cnt <= '0;
                word_cnt <= '0;
                sum      <= '0;
            end
            if (accept) sum <= sum + in_data;

            case (state)
                S_COUNT: if (accept) word_cnt <= {1'b0, in_data};
                S_B0:    if (accept) sm <= in_data[1:0];
                S_B1:    if (accept) d1 <= in_data;
                S_B2:    if (accept) begin
                    im_wdata <= {sm, d1, in_data};
                    im_addr  <= addr_cnt;
                end
                S_WRITE: begin
                    addr_cnt <= addr_cnt + 1'b1;
                    word_cnt <= word_cnt - 9'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;
    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [17:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int vec = 0;
    int errs = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic hold_at_done = 1'b1;
    int wr_n = 0;
    logic [7:0]  wr_addr [0:63];
    logic [17:0] wr_data [0:63];

    instr_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (im_we && wr_n < 64) begin
            wr_addr[wr_n] = im_addr;
            wr_data[wr_n] = im_wdata;
            wr_n++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            hold_at_done = cpu_hold;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            vec++;
            errs++;
            $error("FAIL handshake_timeout observed=in_ready 0 expected=1");
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] f [0:7], input int len, input bit gaps,
                              input int start_at);
        for (int i = 0; i < len; i++) begin
            send_byte(f[i]);
            if (gaps) begin
                in_valid = 1'b0;
                if (i == start_at) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [7:0] good [0:7];
    logic [7:0] bad  [0:7];
    logic [7:0] fmt  [0:7];
    logic [7:0] empty_ok [0:7];
    logic [7:0] empty_bad [0:7];
    int w0;
    int d0;
    int t0;

    initial begin
        good      = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'hAB, 8'hCD, 8'h1D};
        bad       = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'hAB, 8'hCD, 8'h1E};
        fmt       = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        empty_ok  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        empty_bad = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_im_we", im_we, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_im_wdata", im_wdata, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Good frame, in_valid held high
        w0 = wr_n; d0 = done_cnt;
        start_session();
        t0 = cyc;
        chk("start_in_ready", in_ready, 1);
        chk("start_cpu_hold", cpu_hold, 1);
        chk("start_busy", busy, 1);
        send_frame(good, 8, 1'b0, -1);
        @(negedge clk);
        chk("good_done_cnt", done_cnt - d0, 1);
        chk("good_latency", done_cyc - t0, 10);
        chk("good_hold_at_done", hold_at_done, 0);
        chk("good_err", err, 0);
        chk("good_nwr", wr_n - w0, 2);
        chk("good_addr0", wr_addr[w0], 8'h00);
        chk("good_data0", wr_data[w0], 18'h12345);
        chk("good_addr1", wr_addr[w0+1], 8'h01);
        chk("good_data1", wr_data[w0+1], 18'h0ABCD);
        chk("idle_cpu_hold", cpu_hold, 0);
        chk("idle_busy", busy, 0);

        // Bad checksum, then recovery
        w0 = wr_n; d0 = done_cnt;
        start_session();
        send_frame(bad, 8, 1'b0, -1);
        @(negedge clk);
        chk("bcs_nwr", wr_n - w0, 2);
        chk("bcs_data1", wr_data[w0+1], 18'h0ABCD);
        chk("bcs_err", err, 1);
        chk("bcs_done_cnt", done_cnt - d0, 0);
        chk("bcs_cpu_hold", cpu_hold, 1);
        chk("bcs_busy", busy, 0);
        w0 = wr_n; d0 = done_cnt;
        start_session();
        chk("restart_err_clr", err, 0);
        send_frame(good, 8, 1'b0, -1);
        @(negedge clk);
        chk("restart_done_cnt", done_cnt - d0, 1);
        chk("restart_err", err, 0);
        chk("restart_addr0", wr_addr[w0], 8'h00);

        // Format error on b0
        w0 = wr_n;
        start_session();
        send_frame(fmt, 2, 1'b0, -1);
        chk("fmt_err", err, 1);
        chk("fmt_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("fmt_in_ready_hold", in_ready, 0);
        chk("fmt_nwr", wr_n - w0, 0);
        chk("fmt_cpu_hold", cpu_hold, 1);

        // Empty frames
        w0 = wr_n; d0 = done_cnt;
        start_session();
        send_frame(empty_ok, 2, 1'b0, -1);
        @(negedge clk);
        chk("empty_done_cnt", done_cnt - d0, 1);
        chk("empty_nwr", wr_n - w0, 0);
        chk("empty_err", err, 0);
        d0 = done_cnt;
        start_session();
        send_frame(empty_bad, 2, 1'b0, -1);
        @(negedge clk);
        chk("empty_bad_err", err, 1);
        chk("empty_bad_done_cnt", done_cnt - d0, 0);

        // Toggling in_valid with a mid-frame start
        w0 = wr_n; d0 = done_cnt;
        start_session();
        send_frame(good, 8, 1'b1, 2);
        @(negedge clk);
        chk("tog_done_cnt", done_cnt - d0, 1);
        chk("tog_err", err, 0);
        chk("tog_nwr", wr_n - w0, 2);
        chk("tog_addr0", wr_addr[w0], 8'h00);
        chk("tog_data0", wr_data[w0], 18'h12345);
        chk("tog_addr1", wr_addr[w0+1], 8'h01);
        chk("tog_data1", wr_data[w0+1], 18'h0ABCD);

        // Reset during B1 of the second word
        start_session();
        send_frame(good, 5, 1'b0, -1);
        chk("pre_rst_busy", busy, 1);
        w0 = wr_n;
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_cpu_hold", cpu_hold, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_im_wdata", im_wdata, 0);
        chk("mid_rst_im_addr", im_addr, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_nwr", wr_n - w0, 0);
        reset = 1'b0;
        @(negedge clk);
        w0 = wr_n; d0 = done_cnt;
        start_session();
        send_frame(good, 8, 1'b0, -1);
        @(negedge clk);
        chk("post_rst_done_cnt", done_cnt - d0, 1);
        chk("post_rst_addr0", wr_addr[w0], 8'h00);
        chk("post_rst_data0", wr_data[w0], 18'h12345);
        chk("post_rst_addr1", wr_addr[w0+1], 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader for the 8-bit MCU's 18-bit instruction memory. It receives a framed byte stream over a valid/ready handshake and assembles each group of three bytes into one instruction word {SM[1:0], OP[3:0], Data1, Data2, Data3}. It writes the words sequentially into instruction memory from address 0 and verifies an 8-bit checksum. While loading it holds the MCU core in reset through `cpu_hold`; it is the write-side counterpart of the core's instruction fetch path.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction memory address width; depth is 2^ADDR_W words.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load session.
- `in_valid` in 1: source presents a byte.
- `in_data` in 8: byte value.
- `in_ready` out 1: loader accepts a byte this cycle.
- `im_we` out 1: instruction memory write strobe.
- `im_addr` out ADDR_W: write address.
- `im_wdata` out 18: instruction word to write.
- `cpu_hold` out 1: keeps the MCU core in reset.
- `busy` out 1: session in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: error flag; sticky until the next accepted `start` or `reset`.

## Operation
- Frame format: COUNT byte N (0..255), then N×3 word bytes, then one CSUM byte.
- Word bytes in order:
  - b0[1:0] → instr[17:16]; b0[7:2] must be 0.
  - b1 → instr[15:8].
  - b2 → instr[7:0].
- Checksum rule: the mod-256 sum of every frame byte, COUNT and CSUM included, must equal 0x00.
- A byte is accepted on a cycle where `in_valid && in_ready`. `in_data` is ignored otherwise.
- States: IDLE, COUNT, B0, B1, B2, WRITE, CSUM, DONE, ERR.
- IDLE: `start` → COUNT. Clears `err`, address counter, word counter and running sum; sets `cpu_hold`.
- COUNT: on accept, store N and add to the sum.
  - If N > 2^ADDR_W → ERR.
  - Else if N == 0 → CSUM.
  - Else → B0.
- B0: on accept, if b0[7:2] != 0 → ERR (format error, no write). Else → B1.
- B1 → B2 on accept. B2 → WRITE on accept.
- WRITE: exactly one cycle, with `im_we`=1, `im_addr`=address counter, `im_wdata`=assembled word.
  - The address counter increments afterward and the word counter decrements.
  - Then → B0 if words remain, else → CSUM.
- CSUM: on accept, if (sum + byte) mod 256 == 0 → DONE, else → ERR.
- DONE: one cycle with `done`=1 and `cpu_hold` deasserted; → IDLE.
- ERR: `err`=1 and `cpu_hold` stays 1 so a corrupt program never runs. Only `start` (→ COUNT) or `reset` exits. Words already written are not rolled back.
- `start` is ignored in COUNT..DONE. The session is not restartable mid-frame.
- `in_ready`=1 only in COUNT, B0, B1, B2 and CSUM.
- `busy`=1 in every state except IDLE and ERR.
- `im_we`=1 only in WRITE. `im_addr` and `im_wdata` are don't-care elsewhere, but must be stable registered values.
- Address never wraps: N ≤ 2^ADDR_W is checked at COUNT.

## Timing
- All outputs are registered or state-decoded; there is no combinational path from `in_valid` to `in_ready`.
- Reset values: state IDLE; `in_ready`, `im_we`, `cpu_hold`, `busy`, `done`, `err` = 0; `im_addr` = 0; `im_wdata` = 0; all counters and the sum = 0.
- Reset asserted mid-session aborts immediately: no further writes, `cpu_hold` = 0.
- `start` at edge t: state is COUNT at t+1, with `in_ready`=1 and `cpu_hold`=1.
- With `in_valid` held high:
  - Each word costs 4 cycles (3 accepts + WRITE).
  - A full frame costs 1 + 4N + 1 cycles from the first `in_ready`.
  - `done` asserts the cycle after CSUM is accepted.
- `in_valid` gaps stall the FSM in its current state with no timeout.
- Format error: ERR is entered the cycle after the bad b0 is accepted, and `in_ready` drops the same cycle.

## Test plan
- Good frame 02,01,23,45,00,AB,CD,1D with `in_valid` always high → writes addr0=0x12345, addr1=0x0ABCD. `done` pulses once, `err`=0, `cpu_hold` 1→0 at `done`, 10 cycles from start to `done`.
- Same frame with CSUM 0x1E → both writes occur, `err`=1, no `done`, `cpu_hold` stays 1. A following `start` plus the good frame clears `err` and completes.
- Frame 01,04,... → ERR after the second byte, `im_we` never asserts, `in_ready`=0 while in ERR.
- Frame 00,00 → `done` with zero writes; frame 00,01 → `err`.
- Good frame with `in_valid` toggling 1/0 each cycle, plus `start` pulsed mid-frame → identical writes and data; the mid-frame `start` is ignored.
- `reset` asserted during B1 of word 1 → all outputs return to reset values asynchronously; after release a fresh frame loads from address 0.
